// File: rtl/key_matrix_scan_pkg.sv
// Shared keypad-scan definitions: FSM state encoding, default timing and a width helper.
// Used by the scanner and by the play/auto_play control logic.
package key_matrix_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  localparam int DEF_SCAN_DIV = 2000;
  localparam int DEF_DEBOUNCE = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_matrix_scan_tick_gen.sv
// Row-scan divider: tick is high for the one cycle in which the counter sits at SCAN_DIV-1.
// The tick is registered by looking ahead at the next counter value.
module scan_tick_gen
  import key_matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            DW   = cnt_w(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_cnt_nxt_s;

  // Next divider value with wrap at SCAN_DIV-1.
  always_comb begin
    div_cnt_nxt_s = (div_cnt_r == LAST) ? {DW{1'b0}} : div_cnt_r + DW'(1'b1);
  end

  // Divider and registered tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DW{1'b0}};
      tick      <= (LAST == {DW{1'b0}});
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      tick      <= (div_cnt_nxt_s == LAST);
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// Keypad row scanner: drives one row low at a time, debounces the first pressed key
// and reports its code with a one-cycle valid strobe and a held flag.
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [COLS-1:0]                col_n,
  output logic [ROWS-1:0]                row_n,
  output logic [$clog2(ROWS*COLS)-1:0]   key_code,
  output logic                           key_valid,
  output logic                           key_held
);

  localparam int             RW       = cnt_w(ROWS);
  localparam int             CW       = cnt_w(COLS);
  localparam int             DBW      = cnt_w(DEBOUNCE + 1);
  localparam int             KW       = $clog2(ROWS * COLS);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [DBW-1:0] DB_ONE   = DBW'(1'b1);
  localparam logic [DBW-1:0] DB_TGT   = DBW'(DEBOUNCE);

  logic [COLS-1:0] col_meta_r, col_sync_r;
  logic            tick_s;
  scan_state_e     state_r, state_nxt_s;
  logic [RW-1:0]   row_sel_r, row_sel_nxt_s, row_adv_s;
  logic [CW-1:0]   col_sel_r, col_sel_nxt_s, hit_col_s;
  logic [DBW-1:0]  db_cnt_r, db_cnt_nxt_s, db_inc_s;
  logic [KW-1:0]   key_code_nxt_s, code_s;
  logic            key_valid_nxt_s, key_held_nxt_s;
  logic            hit_s, latched_low_s, db_done_s;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // Two-flop synchronizer for the asynchronous, pulled-up columns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta_r <= {COLS{1'b1}};
      col_sync_r <= {COLS{1'b1}};
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Lowest-index low column wins; derived counters and the candidate code.
  always_comb begin
    hit_s     = 1'b0;
    hit_col_s = {CW{1'b0}};
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_sync_r[i]) begin
        hit_s     = 1'b1;
        hit_col_s = CW'(i);
      end else begin
        hit_s     = hit_s;
        hit_col_s = hit_col_s;
      end
    end
    latched_low_s = ~col_sync_r[col_sel_r];
    db_inc_s      = (db_cnt_r == {DBW{1'b1}}) ? db_cnt_r : db_cnt_r + DB_ONE;
    db_done_s     = (db_inc_s >= DB_TGT);
    row_adv_s     = (row_sel_r == ROW_LAST) ? {RW{1'b0}} : row_sel_r + RW'(1'b1);
    code_s        = KW'(int'(row_sel_r) * COLS + int'(col_sel_r));
  end

  // State register plus registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_SCAN;
      row_sel_r <= {RW{1'b0}};
      col_sel_r <= {CW{1'b0}};
      db_cnt_r  <= {DBW{1'b0}};
      row_n     <= ~ROWS'(1'b1);
      key_code  <= {KW{1'b0}};
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      row_sel_r <= row_sel_nxt_s;
      col_sel_r <= col_sel_nxt_s;
      db_cnt_r  <= db_cnt_nxt_s;
      row_n     <= ~(ROWS'(1'b1) << row_sel_nxt_s);
      key_code  <= key_code_nxt_s;
      key_valid <= key_valid_nxt_s;
      key_held  <= key_held_nxt_s;
    end
  end

  // Next-state logic; every transition waits for a tick.
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        ST_SCAN:     state_nxt_s = hit_s ? ST_DEBOUNCE : ST_SCAN;
        ST_DEBOUNCE: state_nxt_s = !latched_low_s ? ST_SCAN : (db_done_s ? ST_HELD : ST_DEBOUNCE);
        ST_HELD:     state_nxt_s = latched_low_s ? ST_HELD : ST_RELEASE;
        ST_RELEASE:  state_nxt_s = latched_low_s ? ST_HELD : (db_done_s ? ST_SCAN : ST_RELEASE);
        default:     state_nxt_s = ST_SCAN;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath logic: row advance, key latch, debounce count and key reporting.
  always_comb begin
    row_sel_nxt_s   = row_sel_r;
    col_sel_nxt_s   = col_sel_r;
    db_cnt_nxt_s    = db_cnt_r;
    key_code_nxt_s  = key_code;
    key_valid_nxt_s = 1'b0;
    key_held_nxt_s  = key_held;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (hit_s) begin
            col_sel_nxt_s = hit_col_s;
            db_cnt_nxt_s  = DB_ONE;
          end else begin
            row_sel_nxt_s = row_adv_s;
          end
        end
        ST_DEBOUNCE: begin
          if (latched_low_s) begin
            db_cnt_nxt_s = db_inc_s;
            if (db_done_s) begin
              key_code_nxt_s  = code_s;
              key_valid_nxt_s = 1'b1;
              key_held_nxt_s  = 1'b1;
            end else begin
              key_valid_nxt_s = 1'b0;
            end
          end else begin
            row_sel_nxt_s = row_adv_s;
          end
        end
        ST_HELD: begin
          if (!latched_low_s) begin
            db_cnt_nxt_s = DB_ONE;
          end else begin
            db_cnt_nxt_s = db_cnt_r;
          end
        end
        ST_RELEASE: begin
          if (!latched_low_s) begin
            db_cnt_nxt_s = db_inc_s;
            if (db_done_s) begin
              key_held_nxt_s = 1'b0;
              row_sel_nxt_s  = row_adv_s;
            end else begin
              key_held_nxt_s = key_held;
            end
          end else begin
            key_held_nxt_s = key_held;
          end
        end
        default: begin
          row_sel_nxt_s = {RW{1'b0}};
        end
      endcase
    end else begin
      key_valid_nxt_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with a keypad model; expected key codes go into a
// scoreboard queue that a monitor pops whenever key_valid is seen.
module tb_key_matrix_scan;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid, key_held;

  logic       press_en = 1'b0;
  int         press_row = 0;
  logic [3:0] press_mask = 4'b0000;

  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_code;
  logic [3:0] exp_row;
  logic [3:0] one_row = 4'b0001;

  key_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: pressed keys pull their columns low only while their row is driven.
  always_comb begin
    col_n = 4'b1111;
    if (press_en && row_n[press_row] == 1'b0) col_n = ~press_mask;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input logic val, input int budget, input string name);
    int n = 0;
    while (key_held !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, key_held}, {31'd0, val});
  endtask

  task automatic wait_row(input logic [3:0] r, input int budget, input string name);
    int n = 0;
    while (row_n !== r && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {28'd0, row_n}, {28'd0, r});
  endtask

  // Monitor: every key_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_key_valid: got code %0d want no pulse", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        check("key_code_at_valid", {28'd0, key_code}, {28'd0, exp_code});
      end
    end
  end

  initial begin
    // 1. reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row_n", {28'd0, row_n}, 32'h0000_000e);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    rst_n = 1'b1;

    // 2. idle scan: each row for SCAN_DIV cycles, wrapping
    for (int k = 0; k < 40; k++) begin
      exp_row = ~(one_row << ((k / 4) % 4));
      check("scan_row", {28'd0, row_n}, {28'd0, exp_row});
      @(negedge clk);
    end

    // 3. row2/col1 press and release
    press_row = 2; press_mask = 4'b0010;
    exp_q.push_back(4'd9);
    press_en = 1'b1;
    wait_held(1'b1, 60, "t3_held_rise");
    check("t3_row_frozen", {28'd0, row_n}, 32'h0000_000b);
    check("t3_code", {28'd0, key_code}, 32'd9);
    cyc(20);
    check("t3_still_held", {31'd0, key_held}, 32'd1);
    check("t3_row_still_frozen", {28'd0, row_n}, 32'h0000_000b);
    press_en = 1'b0;
    wait_held(1'b0, 40, "t3_held_fall");
    check("t3_row_after", {28'd0, row_n}, 32'h0000_0007);

    // 4. bounce: one-tick press on row 2
    wait_row(4'b1011, 40, "t4_reach_row2");
    press_en = 1'b1;
    cyc(4);
    check("t4_frozen", {28'd0, row_n}, 32'h0000_000b);
    press_en = 1'b0;
    cyc(4);
    check("t4_resume", {28'd0, row_n}, 32'h0000_0007);
    check("t4_no_held", {31'd0, key_held}, 32'd0);

    // 5. two keys on row 1: lowest column wins
    press_row = 1; press_mask = 4'b1001;
    exp_q.push_back(4'd4);
    press_en = 1'b1;
    wait_held(1'b1, 80, "t5_held_rise");
    check("t5_code", {28'd0, key_code}, 32'd4);
    press_en = 1'b0;
    wait_held(1'b0, 40, "t5_held_fall");

    // 6. release glitch then full release
    check("t6_code_kept", {28'd0, key_code}, 32'd4);
    press_row = 0; press_mask = 4'b0100;
    exp_q.push_back(4'd2);
    press_en = 1'b1;
    wait_held(1'b1, 80, "t6_held_rise");
    press_en = 1'b0;
    cyc(8);
    press_en = 1'b1;
    cyc(4);
    check("t6_glitch_held", {31'd0, key_held}, 32'd1);
    press_en = 1'b0;
    cyc(11);
    check("t6_before_release", {31'd0, key_held}, 32'd1);
    cyc(1);
    check("t6_release", {31'd0, key_held}, 32'd0);
    check("t6_row_after", {28'd0, row_n}, 32'h0000_000d);

    // 7. reset while held
    press_row = 3; press_mask = 4'b1000;
    exp_q.push_back(4'd15);
    press_en = 1'b1;
    wait_held(1'b1, 80, "t7_held_rise");
    cyc(2);
    rst_n = 1'b0;
    press_en = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("t7_row_n", {28'd0, row_n}, 32'h0000_000e);
    check("t7_key_held", {31'd0, key_held}, 32'd0);
    check("t7_key_valid", {31'd0, key_valid}, 32'd0);
    check("t7_key_code", {28'd0, key_code}, 32'd0);
    cyc(4);
    check("t7_scan_restart", {28'd0, row_n}, 32'h0000_000d);

    cyc(5);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
